// File: rtl/exec_sequencer_if.sv
// Bundles the sequencer's program-memory, ALU-flag and status signals.
// The master side is the sequencer; the slave side is memory/ALU/observer.
interface exec_sequencer_if #(
  parameter int PC_WIDTH = 8
);

  logic                run;
  logic [PC_WIDTH-1:0] mem_addr;
  logic [15:0]         mem_rdata;
  logic [15:0]         ir;
  logic                fetch;
  logic                exec1;
  logic                exec2;
  logic                carryout;
  logic                carryen;
  logic                skipout;
  logic                skipen;
  logic                carrystatus;
  logic                skipstatus;
  logic [PC_WIDTH-1:0] pc;
  logic                halted;

  modport master (
    input  run, mem_rdata, carryout, carryen, skipout, skipen,
    output mem_addr, ir, fetch, exec1, exec2, carrystatus, skipstatus, pc, halted
  );

  modport slave (
    output run, mem_rdata, carryout, carryen, skipout, skipen,
    input  mem_addr, ir, fetch, exec1, exec2, carrystatus, skipstatus, pc, halted
  );

endinterface

// File: rtl/exec_sequencer.sv
// Instruction sequencer for the 16-bit CPU: fetches from synchronous program
// memory into IR', steps the fetch/exec1/exec2 strobes and owns the CARRY and
// SKIP flags that the ALU updates during EXEC1.
module exec_sequencer #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  exec_sequencer_if.master bus
);

  // One-hot encoding so each strobe is a single state bit.
  typedef enum logic [4:0] {
    S_FETCH = 5'b00001,
    S_LOAD  = 5'b00010,
    S_EXEC1 = 5'b00100,
    S_EXEC2 = 5'b01000,
    S_HALT  = 5'b10000
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic                carry_q, carry_d;
  logic                skip_q, skip_d;
  logic                halted_q, halted_d;

  // Next-state, pc/IR' and flag updates for the instruction cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    carry_d  = carry_q;
    skip_d   = skip_q;
    halted_d = halted_q;

    case (state_q)
      S_FETCH: begin
        if (bus.run && !halted_q) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        ir_d = bus.mem_rdata;
        pc_d = pc_q + PC_ONE;
        if (skip_q) begin
          skip_d  = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC1;
        end
      end

      S_EXEC1: begin
        if (bus.carryen) begin
          carry_d = bus.carryout;
        end
        if (bus.skipen) begin
          skip_d = bus.skipout;
        end
        case (ir_q[15:14])
          2'b11:        state_d = S_FETCH;
          2'b01, 2'b10: state_d = S_EXEC2;
          default: begin
            // pc already points past the JMP, so pc-1 is the JMP's own address.
            pc_d = ir_q[PC_WIDTH-1:0];
            if (ir_q[PC_WIDTH-1:0] == (pc_q - PC_ONE)) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              state_d = S_FETCH;
            end
          end
        endcase
      end

      S_EXEC2: state_d = S_FETCH;

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  // State and architectural registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      carry_q  <= 1'b0;
      skip_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      carry_q  <= carry_d;
      skip_q   <= skip_d;
      halted_q <= halted_d;
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.fetch       = (state_q == S_FETCH);
  assign bus.exec1       = (state_q == S_EXEC1);
  assign bus.exec2       = (state_q == S_EXEC2);
  assign bus.carrystatus = carry_q;
  assign bus.skipstatus  = skip_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: a directed vector table walking the
// ALU/skip/memory/JMP/halt program, hand-written wrap and async-reset
// sequences, and a randomized run checked against an instruction-level model.
module tb_exec_sequencer;

  logic clk = 1'b0;
  logic reset;

  exec_sequencer_if #(.PC_WIDTH(8)) bus ();

  exec_sequencer #(
    .PC_WIDTH(8),
    .RESET_PC(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Synchronous program memory: data valid one cycle after the address.
  logic [15:0] mem [256];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic       run;
    logic       ce;
    logic       co;
    logic       se;
    logic       so;
    logic       f;
    logic       e1;
    logic       e2;
    logic [7:0] pc;
    logic       carry;
    logic       skip;
    logic       halted;
  } vec_t;

  vec_t vecs [20];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkStrobes(input string name, input logic f, input logic e1, input logic e2,
                              input logic [7:0] pc);
    checkOutput({name, " fetch"}, 32'(bus.fetch), 32'(f));
    checkOutput({name, " exec1"}, 32'(bus.exec1), 32'(e1));
    checkOutput({name, " exec2"}, 32'(bus.exec2), 32'(e2));
    checkOutput({name, " pc"}, 32'(bus.pc), 32'(pc));
    checkOutput({name, " mem_addr"}, 32'(bus.mem_addr), 32'(pc));
  endtask

  // Drives one cycle of inputs and advances to just after the next rising edge.
  task automatic applyStimulus(input logic r, input logic ce, input logic co,
                               input logic se, input logic so);
    bus.run      = r;
    bus.carryen  = ce;
    bus.carryout = co;
    bus.skipen   = se;
    bus.skipout  = so;
    @(posedge clk);
    #1;
  endtask

  task automatic randomStep(input logic forceRun, output logic r, output logic ce,
                            output logic co, output logic se, output logic so);
    r  = forceRun || ($urandom_range(3) != 0);
    ce = ($urandom_range(1) == 1);
    co = ($urandom_range(1) == 1);
    se = ($urandom_range(3) == 0);
    so = ($urandom_range(1) == 1);
    applyStimulus(r, ce, co, se, so);
  endtask

  task automatic doReset();
    bus.run = 1'b0;
    bus.carryen = 1'b0; bus.carryout = 1'b0;
    bus.skipen = 1'b0;  bus.skipout = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0]  mPc;
  logic        mCarry, mSkip;
  logic [15:0] instr;
  logic        r, ce, co, se, so;
  int          idle;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'hC000;
    mem[0]     = 16'hC000;
    mem[1]     = 16'hC000;
    mem[2]     = 16'hC010;
    mem[3]     = 16'h4000;
    mem[4]     = 16'h0010;
    mem[8'h10] = 16'h0010;

    // run,ce,co,se,so | fetch,exec1,exec2,pc,carry,skip,halted
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h01, 1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h01, 1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h01, 1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,8'h02, 1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h02, 1'b1,1'b1,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,8'h02, 1'b1,1'b1,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h03, 1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h03, 1'b1,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h04, 1'b1,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h04, 1'b1,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h04, 1'b1,1'b0,1'b0};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h04, 1'b1,1'b0,1'b0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h04, 1'b1,1'b0,1'b0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h05, 1'b1,1'b0,1'b0};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h10, 1'b1,1'b0,1'b0};
    vecs[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h10, 1'b1,1'b0,1'b0};
    vecs[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h11, 1'b1,1'b0,1'b0};
    vecs[19] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,8'h10, 1'b1,1'b0,1'b1};

    doReset();
    checkOutput("reset ir", 32'(bus.ir), 32'h0);

    for (int i = 0; i < 20; i++) begin
      checkStrobes($sformatf("row%0d", i), vecs[i].f, vecs[i].e1, vecs[i].e2, vecs[i].pc);
      checkOutput($sformatf("row%0d carry", i), 32'(bus.carrystatus), 32'(vecs[i].carry));
      checkOutput($sformatf("row%0d skip", i), 32'(bus.skipstatus), 32'(vecs[i].skip));
      checkOutput($sformatf("row%0d halted", i), 32'(bus.halted), 32'(vecs[i].halted));
      applyStimulus(vecs[i].run, vecs[i].ce, vecs[i].co, vecs[i].se, vecs[i].so);
    end

    // HALT is terminal while run stays high.
    for (int i = 0; i < 20; i++) begin
      checkStrobes("halt hold", 1'b0, 1'b0, 1'b0, 8'h10);
      checkOutput("halt hold halted", 32'(bus.halted), 32'h1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    checkOutput("halt carry kept", 32'(bus.carrystatus), 32'h1);

    doReset();
    checkOutput("post-halt halted", 32'(bus.halted), 32'h0);
    checkStrobes("post-halt", 1'b1, 1'b0, 1'b0, 8'h00);

    // pc wrap: JMP 0xFF, then an ALU op at 0xFF increments pc to 0x00.
    mem[0]     = 16'h00FF;
    mem[8'hFF] = 16'hC000;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkStrobes("wrap jmp exec1", 1'b0, 1'b1, 1'b0, 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkStrobes("wrap fetch ff", 1'b1, 1'b0, 1'b0, 8'hFF);
    checkOutput("wrap carry set", 32'(bus.carrystatus), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkStrobes("wrap exec1", 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkStrobes("wrap fetch 00", 1'b1, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset in the middle of EXEC1 with carryen high.
    mem[0] = 16'hC000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkStrobes("async pre", 1'b0, 1'b1, 1'b0, 8'h01);
    bus.carryen  = 1'b1;
    bus.carryout = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkStrobes("async reset", 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("async ir", 32'(bus.ir), 32'h0);
    checkOutput("async carry", 32'(bus.carrystatus), 32'h0);
    checkOutput("async skip", 32'(bus.skipstatus), 32'h0);
    checkOutput("async halted", 32'(bus.halted), 32'h0);
    bus.run = 1'b0;
    bus.carryout = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkStrobes("idle run0", 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("idle carry", 32'(bus.carrystatus), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    end

    // Randomized program checked against an instruction-level model.
    for (int a = 0; a < 256; a++) begin
      logic [1:0]  op;
      logic [13:0] low;
      op  = 2'($urandom_range(3));
      low = 14'($urandom);
      if (op == 2'b00 && low[7:0] == 8'(a)) op = 2'b11;
      mem[a] = {op, low};
    end
    doReset();
    mPc = 8'h00; mCarry = 1'b0; mSkip = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r = 1'b0;
      idle = 0;
      while (!r) begin
        checkStrobes("rnd fetch", 1'b1, 1'b0, 1'b0, mPc);
        checkOutput("rnd carry", 32'(bus.carrystatus), 32'(mCarry));
        checkOutput("rnd skip", 32'(bus.skipstatus), 32'(mSkip));
        checkOutput("rnd halted", 32'(bus.halted), 32'h0);
        randomStep(idle > 4, r, ce, co, se, so);
        idle++;
      end
      checkStrobes("rnd load", 1'b0, 1'b0, 1'b0, mPc);
      randomStep(1'b0, r, ce, co, se, so);
      instr = mem[mPc];
      mPc   = mPc + 8'd1;
      if (mSkip) begin
        mSkip = 1'b0;
        continue;
      end
      checkStrobes("rnd exec1", 1'b0, 1'b1, 1'b0, mPc);
      checkOutput("rnd ir", 32'(bus.ir), 32'(instr));
      randomStep(1'b0, r, ce, co, se, so);
      if (ce) mCarry = co;
      if (se) mSkip = so;
      if (instr[15:14] == 2'b00) begin
        mPc = instr[7:0];
      end else if (instr[15:14] != 2'b11) begin
        checkStrobes("rnd exec2", 1'b0, 1'b0, 1'b1, mPc);
        checkOutput("rnd ir exec2", 32'(bus.ir), 32'(instr));
        randomStep(1'b0, r, ce, co, se, so);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
